// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_pkg                                                   |
// | Brief   : Shared UART receiver state encoding and default sizing.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package uart_pkg;

  localparam int c_default_data_bits  = 8;
  localparam int c_default_oversample = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_rx_sync                                               |
// | Brief   : Two-flop Rx synchronizer plus falling-edge detector.       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module uart_rx_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic Rx,
  output logic RxSync,
  output logic RxFall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // All flops reset to the idle-high line level so reset never fakes an edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= Rx;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign RxSync = r_sync;
  assign RxFall = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_rx                                                    |
// | Brief   : Oversampling UART receiver, LSB-first, one stop bit.       |
// |           Define UART_RX_PARITY_EN to add an even-parity bit check.  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = c_default_data_bits,
  parameter int OVERSAMPLE = c_default_oversample
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Tick,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] Data,
  output logic                 DataValid,
  output logic                 FrameError,
`ifdef UART_RX_PARITY_EN
  output logic                 ParityError,
`endif
  output logic                 Busy
);

  localparam int c_cnt_w = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int c_bit_w = $clog2(DATA_BITS + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(OVERSAMPLE - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_half = c_cnt_w'(OVERSAMPLE / 2 - 1);
  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(DATA_BITS - 1);

  logic w_rx_sync;
  logic w_rx_fall;

  uart_rx_sync u_sync (
    .Clk    (Clk),
    .Reset  (Reset),
    .Rx     (Rx),
    .RxSync (w_rx_sync),
    .RxFall (w_rx_fall)
  );

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_tick_cnt;
  logic [c_bit_w-1:0]   r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_data_valid;
  logic                 r_frame_error;
  logic                 r_busy;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bit;
  logic                 r_parity_error;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state        <= IDLE;
      r_tick_cnt     <= '0;
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_data         <= '0;
      r_data_valid   <= 1'b0;
      r_frame_error  <= 1'b0;
      r_busy         <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit      <= 1'b0;
      r_parity_error <= 1'b0;
`endif
    end else begin
      r_data_valid   <= 1'b0;
      r_frame_error  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_error <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_rx_fall) begin
            r_state    <= START;
            r_busy     <= 1'b1;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
          end
        end

        // Re-check the line mid start bit; a high level means it was a glitch.
        START: begin
          if (Tick) begin
            if (r_tick_cnt == c_cnt_half) begin
              r_tick_cnt <= '0;
              if (!w_rx_sync) begin
                r_state <= DATA;
              end else begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (Tick) begin
            if (r_tick_cnt == c_cnt_last) begin
              r_tick_cnt <= '0;
              r_shift    <= {w_rx_sync, r_shift[DATA_BITS-1:1]};
              if (r_bit_cnt == c_bit_last) begin
                r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                r_state   <= PARITY;
`else
                r_state   <= STOP;
`endif
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (Tick) begin
            if (r_tick_cnt == c_cnt_last) begin
              r_tick_cnt <= '0;
              r_par_bit  <= w_rx_sync;
              r_state    <= STOP;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
`endif

        STOP: begin
          if (Tick) begin
            if (r_tick_cnt == c_cnt_last) begin
              r_tick_cnt <= '0;
              r_state    <= IDLE;
              r_busy     <= 1'b0;
              if (!w_rx_sync) begin
                r_frame_error <= 1'b1;
`ifdef UART_RX_PARITY_EN
              end else if (r_par_bit != ^r_shift) begin
                r_parity_error <= 1'b1;
`endif
              end else begin
                r_data       <= r_shift;
                r_data_valid <= 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end

        default: begin
          r_state    <= IDLE;
          r_busy     <= 1'b0;
          r_tick_cnt <= '0;
        end
      endcase
    end
  end

  assign Data        = r_data;
  assign DataValid   = r_data_valid;
  assign FrameError  = r_frame_error;
  assign Busy        = r_busy;
`ifdef UART_RX_PARITY_EN
  assign ParityError = r_parity_error;
`endif

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame (5..8).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, Tick pulses per bit period.
REQ-003 SHALL have port Clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Tick  input  1  single-Clk-cycle oversample strobe at OVERSAMPLE x baud rate.
REQ-006 SHALL have port Rx  input  1  asynchronous serial line; idle high.
REQ-007 SHALL have port Data  output  DATA_BITS  last correctly received word.
REQ-008 SHALL have port DataValid  output  1  one-Clk pulse when Data is updated.
REQ-009 SHALL have port FrameError  output  1  one-Clk pulse when the stop bit samples low.
REQ-010 SHALL have port Busy  output  1  high whenever a frame is in progress.

Function
REQ-011 SHALL pass Rx through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-013 SHALL use a tick counter of width clog2(OVERSAMPLE) that advances only on Tick, is cleared on every state transition, and wraps to 0 after OVERSAMPLE-1.
REQ-014 IDLE: SHALL enter START on a synchronized falling edge (previous 1, current 0); a line held low SHALL NOT retrigger.
REQ-015 START: at tick count OVERSAMPLE/2-1, SHALL enter DATA if Rx is 0 and return to IDLE if Rx is 1 (glitch rejection).
REQ-016 DATA: SHALL sample Rx on every OVERSAMPLE-th Tick and shift LSB-first; after DATA_BITS samples SHALL enter PARITY or STOP.
REQ-017 STOP: on the OVERSAMPLE-th Tick, if Rx is 1 SHALL load Data from the shift register and pulse DataValid; if Rx is 0 SHALL pulse FrameError and leave Data unchanged; in both cases SHALL enter IDLE.
REQ-018 DataValid/FrameError SHALL assert in the Clk cycle after the stop-sampling Tick, for exactly one Clk cycle, and never together.
REQ-019 Busy SHALL be 1 in every state except IDLE.
REQ-020 Data SHALL hold its value between valid frames.
REQ-021 Rx changes between Tick pulses SHALL have no effect except through the synchronizer and edge detector.

Reset
REQ-022 Reset low SHALL immediately force IDLE, clear the tick and bit counters, set Data=0, DataValid=0, FrameError=0, Busy=0, and set the synchronizer flops to 1.
REQ-023 Reset mid-frame SHALL discard the partial word; the next frame SHALL require a fresh falling edge.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: SHALL add output ParityError (1 bit); after DATA, the PARITY state samples one bit; even parity SHALL be checked (received bit equals XOR of data bits); on mismatch SHALL pulse ParityError instead of DataValid at stop sampling, with Data unchanged.
REQ-025 Macro undefined: SHALL have no PARITY state and no ParityError port; DATA goes directly to STOP.

Structure
REQ-026 Shared package uart_pkg SHALL hold the state enumeration and the default DATA_BITS/OVERSAMPLE constants.
REQ-027 The synchronizer and edge detector SHALL be a sub-module uart_rx_sync (inputs Clk, Reset, Rx; outputs RxSync, RxFall).

Verification
REQ-028 Frame 0xA5, stop=1, 16 Ticks/bit -> Data=0xA5, one-cycle DataValid, FrameError=0, Busy low after stop.
REQ-029 Rx low for 4 Ticks then high -> no DataValid, Busy returns to 0 by tick 7, Data unchanged.
REQ-030 Frame 0x3C, stop=0 -> one-cycle FrameError, no DataValid, Data keeps previous value.
REQ-031 Back-to-back 0x00 then 0xFF, no idle gap -> two DataValid pulses, Data=0x00 then 0xFF.
REQ-032 Reset asserted during data bit 3 -> Busy=0 and Data=0x00 same cycle; next full frame 0x5A received correctly.
REQ-033 With UART_RX_PARITY_EN: 0x07 with parity bit 0 -> one-cycle ParityError, no DataValid; with parity bit 1 -> Data=0x07, DataValid.
